// File: rtl/seg7_mux_clock_if.sv
// Board-side signals of the multiplexed 7-segment clock: button levels in,
// scanned display out.
interface seg7_mux_clock_if #(
    parameter int DIGITS = 4
);
    // No valid/ready pairing: buttons are free asynchronous levels and the display free-runs.
    logic              inc_min;
    logic              inc_hour;
    logic              hold;
    logic [6:0]        seg;
    logic              dp;
    logic [DIGITS-1:0] dig_sel;

    modport master (output inc_min, inc_hour, hold, input seg, dp, dig_sel);
    modport slave  (input inc_min, inc_hour, hold, output seg, dp, dig_sel);
endinterface

// File: rtl/seg7_mux_clock.sv
// BCD hh:mm(:ss) real-time clock with synchronised set buttons, hold, and a
// multiplexed common-cathode display scanner with a blinking colon.
module seg7_mux_clock #(
    parameter int DIGITS        = 4,
    parameter int TICK_DIV      = 1000,
    parameter int SCAN_DIV      = 4,
    parameter int LEADING_BLANK = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    seg7_mux_clock_if.slave  bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DIGITS);

    localparam logic [PW-1:0]     PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]     HALF    = PW'(TICK_DIV / 2);
    localparam logic [SW-1:0]     SC_MAX  = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0]     DI_MAX  = DW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] SEL0    = DIGITS'(1);

    logic [2:0]        msync, hsync_b;
    logic [1:0]        hold_sync;
    logic              pmin, phour;
    logic              hold_s;
    logic [PW-1:0]     pre;
    logic [6:0]        sec, min;
    logic [5:0]        hr;
    logic [SW-1:0]     sc;
    logic [DW-1:0]     di;
    logic [3:0]        nib;
    logic              blank;
    logic [6:0]        seg_r;
    logic              dp_r;
    logic [DIGITS-1:0] sel_r;

    function automatic logic [6:0] inc60(input logic [6:0] v);
        if (v[3:0] == 4'd9) inc60 = (v[6:4] == 3'd5) ? 7'd0 : {v[6:4] + 3'd1, 4'd0};
        else                inc60 = {v[6:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [5:0] inc24(input logic [5:0] v);
        if (v == 6'h23)          inc24 = 6'd0;
        else if (v[3:0] == 4'd9) inc24 = {v[5:4] + 2'd1, 4'd0};
        else                     inc24 = {v[5:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'h3F;
            4'd1:    seg_code = 7'h06;
            4'd2:    seg_code = 7'h5B;
            4'd3:    seg_code = 7'h4F;
            4'd4:    seg_code = 7'h66;
            4'd5:    seg_code = 7'h6D;
            4'd6:    seg_code = 7'h7D;
            4'd7:    seg_code = 7'h07;
            4'd8:    seg_code = 7'h7F;
            4'd9:    seg_code = 7'h6F;
            default: seg_code = 7'h00;
        endcase
    endfunction

    // The edge pulse is registered so a button sampled at edge N lands on the counters at N+3.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msync     <= 3'b000;
            hsync_b   <= 3'b000;
            hold_sync <= 2'b00;
            pmin      <= 1'b0;
            phour     <= 1'b0;
        end else begin
            msync     <= {msync[1:0], bus.inc_min};
            hsync_b   <= {hsync_b[1:0], bus.inc_hour};
            hold_sync <= {hold_sync[0], bus.hold};
            pmin      <= msync[1] & ~msync[2];
            phour     <= hsync_b[1] & ~hsync_b[2];
        end
    end

    assign hold_s = hold_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
            sec <= 7'd0;
            min <= 7'd0;
            hr  <= 6'd0;
        end else if (pmin || phour) begin
            // A button pulse restarts the second and swallows any coincident tick.
            pre <= '0;
            sec <= 7'd0;
            if (pmin)  min <= inc60(min);
            if (phour) hr  <= inc24(hr);
        end else if (!hold_s) begin
            if (pre == PRE_MAX) begin
                pre <= '0;
                sec <= inc60(sec);
                if (sec == 7'h59) begin
                    min <= inc60(min);
                    if (min == 7'h59) hr <= inc24(hr);
                end
            end else begin
                pre <= pre + PW'(1);
            end
        end
    end

    always_comb begin
        nib   = 4'd0;
        blank = 1'b0;
        if (DIGITS == 6) begin
            case (int'(di))
                0: nib = sec[3:0];
                1: nib = {1'b0, sec[6:4]};
                2: nib = min[3:0];
                3: nib = {1'b0, min[6:4]};
                4: nib = hr[3:0];
                5: begin
                    nib   = {2'b00, hr[5:4]};
                    blank = (LEADING_BLANK != 0) && (hr[5:4] == 2'd0);
                end
                default: nib = 4'd0;
            endcase
        end else begin
            case (int'(di))
                0: nib = min[3:0];
                1: nib = {1'b0, min[6:4]};
                2: nib = hr[3:0];
                3: begin
                    nib   = {2'b00, hr[5:4]};
                    blank = (LEADING_BLANK != 0) && (hr[5:4] == 2'd0);
                end
                default: nib = 4'd0;
            endcase
        end
    end

    // seg, dp and dig_sel all register from the same di so they never disagree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc    <= '0;
            di    <= '0;
            seg_r <= 7'h3F;
            dp_r  <= 1'b0;
            sel_r <= SEL0;
        end else begin
            if (sc == SC_MAX) begin
                sc <= '0;
                di <= (di == DI_MAX) ? '0 : di + DW'(1);
            end else begin
                sc <= sc + SW'(1);
            end
            seg_r <= blank ? 7'h00 : seg_code(nib);
            dp_r  <= ~di[0] && (di != '0) && (pre < HALF);
            sel_r <= SEL0 << di;
        end
    end

    assign bus.seg     = seg_r;
    assign bus.dp      = dp_r;
    assign bus.dig_sel = sel_r;
endmodule

// File: doc/seg7_mux_clock.md
# seg7_mux_clock

Parametrised multiplexed 7-segment real-time clock core, successor to the single-display 7-segment clock top. It keeps hours/minutes/seconds in BCD, scans DIGITS common-cathode digits over a shared segment bus, and accepts debounced-externally set buttons. It sits directly under the Tiny Tapeout top wrapper, with io_in/io_out mapped by that wrapper.

## Interface
- DIGITS, 4: displayed digits; legal values are 4 (HH MM) or 6 (HH MM SS).
- TICK_DIV, 1000: clk cycles per one-second tick (≥2).
- SCAN_DIV, 4: clk cycles each digit stays selected (≥1).
- LEADING_BLANK, 1: when 1, the hours-tens digit is blanked if it is 0.

- clk  in  1  single clock; all state is on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- inc_min  in  1  asynchronous level input; each rising edge advances minutes.
- inc_hour  in  1  asynchronous level input; each rising edge advances hours.
- hold  in  1  asynchronous level input; while 1, timekeeping is frozen but scanning continues.
- seg  out  7  segments {g,f,e,d,c,b,a}, bit0=a, active-high, registered.
- dp  out  1  colon/decimal point, active-high, registered.
- dig_sel  out  DIGITS  one-hot digit enable, bit0 = rightmost digit, registered.

## Operation
- Prescaler `pre` counts 0..TICK_DIV-1 and wraps. `tick` is asserted in the cycle with pre==TICK_DIV-1 and hold==0. While hold==1, pre does not advance.
- BCD time: seconds 00–59, minutes 00–59, hours 00–23. Tick increments seconds. 59→00 carries to minutes, and 59→00 there carries to hours. Hours 23→00 wraps. Seconds are counted even when DIGITS=4.
- Each input passes a 2-flop synchroniser, then a third flop for edge detection. A single-cycle pulse is generated when stage2=1 and stage3=0.
- inc_min pulse: minutes +1 mod 60 with no carry to hours. Seconds and pre are cleared.
- inc_hour pulse: hours +1 mod 24. Seconds and pre are cleared.
- Both pulses in the same cycle: both fields increment and seconds/pre are cleared once.
- A pulse coinciding with a tick: the pulse wins and that tick is discarded.
- The buttons work regardless of hold.
- Scanner: counter `sc` counts 0..SCAN_DIV-1. On wrap, digit index `di` advances 0..DIGITS-1 and wraps to 0.
- Digit mapping for DIGITS=4: di0=min ones, di1=min tens, di2=hr ones, di3=hr tens.
- Digit mapping for DIGITS=6: di0=sec ones, di1=sec tens, di2=min ones, di3=min tens, di4=hr ones, di5=hr tens.
- Segment codes: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F. A blanked digit outputs 00.
- dp is 1 only when di is even and nonzero, and pre < TICK_DIV/2 (integer divide). This gives the colon blink. While hold==1, dp stays at its frozen-pre value.

## Timing
- Reset (rst_n=0, asynchronous) sets the following, held while rst_n=0:
  - time 00:00:00, pre=0, sc=0, di=0
  - synchroniser flops = 0
  - seg=3F, dp=0, dig_sel=1 (one-hot bit0)
- Release is synchronous to the next edge. The first tick occurs TICK_DIV cycles after release.
- seg, dp and dig_sel are registered from the current di and counters, with 1-cycle latency. They always change together, so there is never a cycle where a new dig_sel shows stale seg.
- Button latency: inc_* first sampled high at edge N gives the pulse during the cycle after edge N+2. The counter is updated at edge N+3, and seg reflects the change at edge N+4 if that digit is selected.
- Each dig_sel value is held exactly SCAN_DIV cycles. One full frame lasts DIGITS×SCAN_DIV cycles.
- Reset asserted mid-frame or mid-tick returns everything to reset values immediately. No partial increment survives.

## Test plan
- Reset, DIGITS=4, LEADING_BLANK=0: during and 1 cycle after reset, seg=3F, dp=0, dig_sel=0001.
- Scan, DIGITS=4, SCAN_DIV=2: dig_sel sequence 0001,0010,0100,1000,0001, each value held 2 cycles. On hr-tens with LEADING_BLANK=1 at 00:00, seg=00.
- Rollover, DIGITS=6, TICK_DIV=10: set 23:59 via 23 inc_hour and 59 inc_min edges, then run 600 cycles. Displayed time = 00:00:00 with no glitch value 24:xx.
- Minute wrap: at minutes 59, one inc_min edge gives minutes=00 and hours unchanged. Seconds=00, and the next tick arrives TICK_DIV cycles after the pulse.
- hold=1 for 50 ticks' worth of cycles: time unchanged and dig_sel keeps scanning. After hold=0, seconds resume from the frozen value.
- Async reset mid-frame at 12:34:56, with rst_n dropped between clock edges: outputs reach reset values before the next edge.
